// File: rtl/l1_dcache_dm.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// 32-bit CPU word port in front of a 256-bit physical-memory line port.
module l1_dcache_dm #(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);
  localparam int SETS = 2 ** S_INDEX;
  localparam int TW   = 27 - S_INDEX;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_t;

  state_t r_state, w_state_n;

  logic [SETS-1:0] r_valid;
  logic [SETS-1:0] r_dirty;
  logic [TW-1:0]   r_tag  [SETS];
  logic [255:0]    r_data [SETS];

  logic [2:0]         w_word;
  logic [S_INDEX-1:0] w_idx;
  logic [TW-1:0]      w_tag;
  logic               w_req;
  logic               w_hit;
  logic               w_wr_hit;
  logic               w_wb_done;
  logic               w_fill_done;
  logic [31:0]        w_rword;
  logic [31:0]        w_wmerge;
  logic               w_unused;

  assign w_word   = mem_address[4:2];
  assign w_idx    = mem_address[4+S_INDEX:5];
  assign w_tag    = mem_address[31:5+S_INDEX];
  assign w_unused = ^mem_address[1:0];

  assign w_req = mem_read | mem_write;
  assign w_hit = w_req && r_valid[w_idx]
              && (r_tag[w_idx] == w_tag);

  assign w_rword   = r_data[w_idx][{w_word, 5'b0} +: 32];
  assign mem_rdata = w_rword;

  assign w_wr_hit    = (r_state == S_IDLE) && w_hit && mem_write;
  assign w_wb_done   = (r_state == S_WB) && pmem_resp;
  assign w_fill_done = (r_state == S_FILL) && pmem_resp;

  always_comb begin
    w_wmerge = w_rword;
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b])
        w_wmerge[b*8 +: 8] = mem_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (w_wr_hit)  r_dirty[w_idx] <= 1'b1;
      if (w_wb_done) r_dirty[w_idx] <= 1'b0;
      if (w_fill_done) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
    end
  end

  // Tag/data arrays are not cleared; reset only gates their update.
  always_ff @(posedge clk) begin
    if (rst && w_fill_done) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= pmem_rdata;
    end
    if (rst && w_wr_hit)
      r_data[w_idx][{w_word, 5'b0} +: 32] <= w_wmerge;
  end

  always_comb begin
    w_state_n    = r_state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {w_tag, w_idx, 5'b0};
    pmem_wdata   = r_data[w_idx];
    unique case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          mem_resp = 1'b1;
        end else if (w_req) begin
          if (r_valid[w_idx] && r_dirty[w_idx])
            w_state_n = S_WB;
          else
            w_state_n = S_FILL;
        end
      end
      S_WB: begin
        pmem_write   = 1'b1;
        pmem_address = {r_tag[w_idx], w_idx, 5'b0};
        if (pmem_resp) w_state_n = S_FILL;
      end
      S_FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_l1_dcache_dm.sv
// Randomized bench for l1_dcache_dm against a flat-memory model
// plus a per-set valid/dirty/line-address shadow.
module tb_l1_dcache_dm;
  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address, mem_wdata, mem_rdata;
  logic         mem_resp;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l1_dcache_dm #(.S_INDEX(3)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // gmem: what the CPU must observe; pmem: backing store contents.
  logic [255:0] gmem [logic [26:0]];
  logic [255:0] pmem [logic [26:0]];
  logic         mvalid [8];
  logic         mdirty [8];
  logic [26:0]  mla    [8];

  function automatic logic [255:0] init_line(logic [26:0] la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++)
      l[k*32 +: 32] = {5'b0, la} * 32'h9E3779B1 + 32'(k) * 32'h01030507;
    return l;
  endfunction

  function automatic logic [255:0] g_get(logic [26:0] la);
    if (gmem.exists(la)) return gmem[la];
    return init_line(la);
  endfunction

  function automatic logic [255:0] p_get(logic [26:0] la);
    if (pmem.exists(la)) return pmem[la];
    return init_line(la);
  endfunction

  task automatic chk(input string n, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      if (mvalid[i] && mdirty[i]) gmem[mla[i]] = p_get(mla[i]);
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
  endtask

  // Entered and left at posedge+1 with no request driven.
  task automatic do_req(input bit wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input int dwb, input int dfl,
                        output logic [31:0] rd, output int nrd,
                        output int nwr, output logic [31:0] wb0);
    logic [26:0]  la, vla;
    logic [2:0]   idx, w;
    logic         hit, wb;
    logic [255:0] l;
    int           tot, wbend;
    la  = a[31:5];
    idx = a[7:5];
    w   = a[4:2];
    vla = mla[idx];
    hit = mvalid[idx] && (mla[idx] == la);
    wb  = !hit && mvalid[idx] && mdirty[idx];
    wbend = wb ? dwb + 1 : 0;
    tot = hit ? 1 : 1 + wbend + dfl + 1 + 1;
    nrd = 0; nwr = 0; rd = '0; wb0 = '0;
    mem_read = !wr; mem_write = wr;
    mem_address = a; mem_byte_enable = be; mem_wdata = wd;
    for (int c = 0; c < tot; c++) begin
      @(negedge clk);
      if (pmem_read)  nrd++;
      if (pmem_write) begin nwr++; wb0 = pmem_wdata[31:0]; end
      if (c == tot - 1) begin
        chk("hit_resp", mem_resp, 1);
        chk("hit_strobes", {pmem_read, pmem_write}, 0);
        rd = mem_rdata;
        l = g_get(la);
        if (!wr) chk("rdata", mem_rdata, l[{w, 5'b0} +: 32]);
      end else if (c == 0) begin
        chk("miss_resp", mem_resp, 0);
        chk("miss_strobes", {pmem_read, pmem_write}, 0);
      end else if (c <= wbend) begin
        chk("wb_strobes", {pmem_read, pmem_write, mem_resp}, 3'b010);
        chk("wb_addr", pmem_address, {vla, 5'b0});
        chk("wb_data", pmem_wdata, g_get(vla));
        pmem_resp = (c == wbend);
        if (c == wbend) pmem[vla] = g_get(vla);
      end else begin
        chk("fill_strobes", {pmem_read, pmem_write, mem_resp}, 3'b100);
        chk("fill_addr", pmem_address, {la, 5'b0});
        pmem_rdata = p_get(la);
        pmem_resp = (c == tot - 2);
      end
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    if (!hit) begin
      mvalid[idx] = 1'b1; mdirty[idx] = 1'b0; mla[idx] = la;
    end
    if (wr) begin
      l = g_get(la);
      for (int b = 0; b < 4; b++)
        if (be[b]) l[{w, 5'b0} + 8*b +: 8] = wd[b*8 +: 8];
      gmem[la] = l;
      mdirty[idx] = 1'b1;
    end
  endtask

  task automatic idle_cycle();
    pmem_resp = 1'($urandom_range(0, 1));
    mem_address = $urandom;
    @(negedge clk);
    chk("idle", {mem_resp, pmem_read, pmem_write}, 0);
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("post_reset", {mem_resp, pmem_read, pmem_write}, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0]  rd, wb0, a;
    int           nrd, nwr, t;
    bit           wr;
    logic [255:0] l;
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = '0; mem_address = '0; mem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0; mdirty[i] = 1'b0; mla[i] = '0;
    end
    l = init_line(27'h2);
    l[31:0] = 32'hDEADBEEF;
    l[63:32] = 32'h0BADF00D;
    pmem[27'h2] = l; gmem[27'h2] = l;
    l = init_line(27'hA);
    l[31:0] = 32'h11112222;
    pmem[27'hA] = l; gmem[27'hA] = l;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    do_req(0, 32'h40, 4'hF, 0, 0, 2, rd, nrd, nwr, wb0);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_nrd", nrd, 3);
    chk("t1_nwr", nwr, 0);

    do_req(0, 32'h44, 4'hF, 0, 0, 0, rd, nrd, nwr, wb0);
    chk("t2_rdata", rd, 32'h0BADF00D);
    chk("t2_traffic", nrd + nwr, 0);

    do_req(1, 32'h40, 4'b0011, 32'h12345678, 0, 0, rd, nrd, nwr, wb0);
    chk("t3_wr_traffic", nrd + nwr, 0);
    do_req(0, 32'h40, 4'hF, 0, 0, 0, rd, nrd, nwr, wb0);
    chk("t3_rdata", rd, 32'hDEAD5678);
    chk("t3_rd_traffic", nrd + nwr, 0);

    do_req(0, 32'h140, 4'hF, 0, 0, 0, rd, nrd, nwr, wb0);
    chk("t4_wb0", wb0, 32'hDEAD5678);
    chk("t4_nwr", nwr, 1);
    chk("t4_nrd", nrd, 1);
    chk("t4_rdata", rd, 32'h11112222);

    do_req(0, 32'h180, 4'hF, 0, 0, 10, rd, nrd, nwr, wb0);
    chk("t5_nrd", nrd, 11);

    do_req(1, 32'h144, 4'hF, 32'hA5A5A5A5, 0, 0, rd, nrd, nwr, wb0);
    chk("t6_dirty_hit", nrd + nwr, 0);
    mem_read = 1'b1; mem_address = 32'h80;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t6_in_fill", {pmem_read, pmem_write}, 2'b10);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1; mem_read = 1'b0;
    model_reset();
    @(negedge clk);
    chk("t6_abort", {mem_resp, pmem_read, pmem_write}, 0);
    @(posedge clk);
    #1;
    do_req(0, 32'h40, 4'hF, 0, 0, 0, rd, nrd, nwr, wb0);
    chk("t6_nwr", nwr, 0);
    chk("t6_nrd", nrd, 1);
    chk("t6_rdata", rd, 32'hDEAD5678);

    for (int n = 0; n < 400; n++) begin
      t = $urandom_range(0, 3);
      a = {(t == 3) ? 24'hABCDE : 24'(t),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3))};
      wr = 1'($urandom_range(0, 1));
      do_req(wr, a, 4'($urandom_range(0, 15)), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3),
             rd, nrd, nwr, wb0);
      if ($urandom_range(0, 3) == 0) idle_cycle();
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
